// File: rtl/mem_access_pkg.sv
// rtl/mem_access_pkg.sv - shared types and helpers for the MEM-stage load/store unit
package mem_access_pkg;

  typedef enum logic [2:0] {
    MF_BS = 3'b000,
    MF_HS = 3'b001,
    MF_W  = 3'b010,
    MF_BU = 3'b100,
    MF_HU = 3'b101
  } memfunc_t;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  localparam logic [3:0] BE_BYTE    = 4'b0001;
  localparam logic [3:0] BE_HALF_LO = 4'b0011;
  localparam logic [3:0] BE_HALF_HI = 4'b1100;
  localparam logic [3:0] BE_WORD    = 4'b1111;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  typedef struct packed {
    logic       is_store;
    logic [2:0] memfunc;
    logic [1:0] lane;
    logic       reg_write;
    logic       mem_to_reg;
    logic [4:0] raddr;
  } txn_t;

  // Low two memfunc bits give the access size for loads and stores alike.
  function automatic logic [1:0] access_size(input logic [2:0] mf);
    case (mf[1:0])
      2'b00:   return SZ_BYTE;
      2'b01:   return SZ_HALF;
      default: return SZ_WORD;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [2:0] mf, input logic [1:0] low);
    case (access_size(mf))
      SZ_BYTE: return 1'b0;
      SZ_HALF: return low[0];
      default: return |low;
    endcase
  endfunction

endpackage

// File: rtl/mem_load_extend.sv
// rtl/mem_load_extend.sv - lane select and sign/zero extension of load data
module mem_load_extend
  import mem_access_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  lane,
  input  logic [2:0]  memfunc,
  output logic [31:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata[{lane, 3'b000} +: 8];
    half_sel = lane[1] ? rdata[31:16] : rdata[15:0];
    data     = rdata;
    case (memfunc)
      MF_BS:   data = {{24{byte_sel[7]}}, byte_sel};
      MF_BU:   data = {24'h0, byte_sel};
      MF_HS:   data = {{16{half_sel[15]}}, half_sel};
      MF_HU:   data = {16'h0, half_sel};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - MEM-stage load/store unit with a single outstanding req/ack transaction
// Optional misalignment trap and AddrErr port: define MEM_ALIGN_CHECK_EN.
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int ADDR_W = 32
)
(
  input  logic              Clock,
  input  logic              nReset,
  input  logic              RegWriteIn,
  input  logic              MemReadIn,
  input  logic              MemtoRegIn,
  input  logic              MemWriteIn,
  input  logic [2:0]        MemfuncIn,
  input  logic [ADDR_W-1:0] AddrIn,
  input  logic [31:0]       RtDataIn,
  input  logic [4:0]        RAddrIn,
  output logic              Stall,
  output logic              MemReq,
  output logic              MemWe,
  output logic [ADDR_W-1:0] MemAddr,
  output logic [3:0]        MemBe,
  output logic [31:0]       MemWData,
  input  logic [31:0]       MemRData,
  input  logic              MemAck,
  output logic              RegWriteOut,
  output logic              MemtoRegOut,
  output logic [4:0]        RAddrOut,
  output logic [31:0]       ResultOut
`ifdef MEM_ALIGN_CHECK_EN
  ,
  output logic              AddrErr
`endif
);

  state_t            state_q, state_d;
  txn_t              txn_q, txn_d;
  logic [ADDR_W-1:0] addr_q, addr_d;

  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [3:0]        mem_be_q, mem_be_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic              reg_write_out_q, reg_write_out_d;
  logic              mem_to_reg_out_q, mem_to_reg_out_d;
  logic [4:0]        raddr_out_q, raddr_out_d;
  logic [31:0]       result_q, result_d;
`ifdef MEM_ALIGN_CHECK_EN
  logic              addr_err_q, addr_err_d;
`endif

  logic        mem_op;
  logic        align_err;
  logic [3:0]  be_new;
  logic [31:0] wdata_new;
  logic [31:0] load_data;

  assign mem_op = MemReadIn | MemWriteIn;

`ifdef MEM_ALIGN_CHECK_EN
  assign align_err = mem_op & is_misaligned(MemfuncIn, AddrIn[1:0]);
`else
  assign align_err = 1'b0;
`endif

  always_comb begin
    be_new    = BE_WORD;
    wdata_new = RtDataIn;
    case (access_size(MemfuncIn))
      SZ_BYTE: begin
        be_new    = BE_BYTE << AddrIn[1:0];
        wdata_new = {4{RtDataIn[7:0]}};
      end
      SZ_HALF: begin
        be_new    = AddrIn[1] ? BE_HALF_HI : BE_HALF_LO;
        wdata_new = {2{RtDataIn[15:0]}};
      end
      default: begin
        be_new    = BE_WORD;
        wdata_new = RtDataIn;
      end
    endcase
  end

  mem_load_extend u_load_extend (
    .rdata   (MemRData),
    .lane    (txn_q.lane),
    .memfunc (txn_q.memfunc),
    .data    (load_data)
  );

  // Stall releases in the ack cycle so upstream advances alongside the writeback.
  assign Stall = (state_q == IDLE) ? (mem_op & ~align_err) : ~MemAck;

  always_comb begin
    state_d          = state_q;
    txn_d            = txn_q;
    addr_d           = addr_q;
    mem_req_d        = mem_req_q;
    mem_we_d         = mem_we_q;
    mem_addr_d       = mem_addr_q;
    mem_be_d         = mem_be_q;
    mem_wdata_d      = mem_wdata_q;
    reg_write_out_d  = reg_write_out_q;
    mem_to_reg_out_d = mem_to_reg_out_q;
    raddr_out_d      = raddr_out_q;
    result_d         = result_q;
`ifdef MEM_ALIGN_CHECK_EN
    addr_err_d       = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (mem_op && !align_err) begin
          state_d          = BUSY;
          txn_d.is_store   = MemWriteIn;
          txn_d.memfunc    = MemfuncIn;
          txn_d.lane       = AddrIn[1:0];
          txn_d.reg_write  = RegWriteIn;
          txn_d.mem_to_reg = MemtoRegIn;
          txn_d.raddr      = RAddrIn;
          addr_d           = AddrIn;
          mem_req_d        = 1'b1;
          mem_we_d         = MemWriteIn;
          mem_addr_d       = {AddrIn[ADDR_W-1:2], 2'b00};
          mem_be_d         = be_new;
          mem_wdata_d      = wdata_new;
          reg_write_out_d  = 1'b0;
        end else if (align_err) begin
          reg_write_out_d  = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
          addr_err_d       = 1'b1;
`endif
        end else begin
          reg_write_out_d  = RegWriteIn;
          mem_to_reg_out_d = MemtoRegIn;
          raddr_out_d      = RAddrIn;
          result_d         = 32'(AddrIn);
        end
      end
      BUSY: begin
        if (MemAck) begin
          state_d          = IDLE;
          mem_req_d        = 1'b0;
          reg_write_out_d  = txn_q.reg_write;
          mem_to_reg_out_d = txn_q.mem_to_reg;
          raddr_out_d      = txn_q.raddr;
          result_d         = txn_q.is_store ? 32'(addr_q) : load_data;
        end else begin
          reg_write_out_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (!nReset) begin
      state_q          <= IDLE;
      txn_q            <= '0;
      addr_q           <= '0;
      mem_req_q        <= 1'b0;
      mem_we_q         <= 1'b0;
      mem_addr_q       <= '0;
      mem_be_q         <= '0;
      mem_wdata_q      <= '0;
      reg_write_out_q  <= 1'b0;
      mem_to_reg_out_q <= 1'b0;
      raddr_out_q      <= '0;
      result_q         <= '0;
`ifdef MEM_ALIGN_CHECK_EN
      addr_err_q       <= 1'b0;
`endif
    end else begin
      state_q          <= state_d;
      txn_q            <= txn_d;
      addr_q           <= addr_d;
      mem_req_q        <= mem_req_d;
      mem_we_q         <= mem_we_d;
      mem_addr_q       <= mem_addr_d;
      mem_be_q         <= mem_be_d;
      mem_wdata_q      <= mem_wdata_d;
      reg_write_out_q  <= reg_write_out_d;
      mem_to_reg_out_q <= mem_to_reg_out_d;
      raddr_out_q      <= raddr_out_d;
      result_q         <= result_d;
`ifdef MEM_ALIGN_CHECK_EN
      addr_err_q       <= addr_err_d;
`endif
    end
  end

  assign MemReq      = mem_req_q;
  assign MemWe       = mem_we_q;
  assign MemAddr     = mem_addr_q;
  assign MemBe       = mem_be_q;
  assign MemWData    = mem_wdata_q;
  assign RegWriteOut = reg_write_out_q;
  assign MemtoRegOut = mem_to_reg_out_q;
  assign RAddrOut    = raddr_out_q;
  assign ResultOut   = result_q;
`ifdef MEM_ALIGN_CHECK_EN
  assign AddrErr     = addr_err_q;
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - self-checking bench for mem_access_unit
module tb_mem_access_unit;

  logic        Clock;
  logic        nReset;
  logic        RegWriteIn, MemReadIn, MemtoRegIn, MemWriteIn;
  logic [2:0]  MemfuncIn;
  logic [31:0] AddrIn, RtDataIn, MemRData;
  logic [4:0]  RAddrIn;
  logic        MemAck;
  logic        Stall, MemReq, MemWe, RegWriteOut, MemtoRegOut;
  logic [31:0] MemAddr, MemWData, ResultOut;
  logic [3:0]  MemBe;
  logic [4:0]  RAddrOut;
`ifdef MEM_ALIGN_CHECK_EN
  logic        AddrErr;
`endif

  mem_access_unit #(.ADDR_W(32)) dut (
    .Clock(Clock), .nReset(nReset),
    .RegWriteIn(RegWriteIn), .MemReadIn(MemReadIn), .MemtoRegIn(MemtoRegIn), .MemWriteIn(MemWriteIn),
    .MemfuncIn(MemfuncIn), .AddrIn(AddrIn), .RtDataIn(RtDataIn), .RAddrIn(RAddrIn),
    .Stall(Stall), .MemReq(MemReq), .MemWe(MemWe), .MemAddr(MemAddr), .MemBe(MemBe),
    .MemWData(MemWData), .MemRData(MemRData), .MemAck(MemAck),
    .RegWriteOut(RegWriteOut), .MemtoRegOut(MemtoRegOut), .RAddrOut(RAddrOut), .ResultOut(ResultOut)
`ifdef MEM_ALIGN_CHECK_EN
    , .AddrErr(AddrErr)
`endif
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic        rw, mr, m2r, mw;
    logic [2:0]  mf;
    logic [31:0] addr, rt;
    logic [4:0]  raddr;
    logic [31:0] rdata;
    int          delay;
    logic [31:0] exp_res;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
  } vec_t;

  vec_t tbl[13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  // Reference rules: loads use the listed code table, stores use bits [1:0].
  function automatic int load_size(input logic [2:0] mf);
    case (mf)
      3'd0, 3'd4: return 1;
      3'd1, 3'd5: return 2;
      default:    return 4;
    endcase
  endfunction

  function automatic int store_size(input logic [2:0] mf);
    if (mf[1:0] == 2'd0) return 1;
    if (mf[1:0] == 2'd1) return 2;
    return 4;
  endfunction

  function automatic int lane_off(input int sz, input logic [31:0] addr);
    if (sz == 1) return int'(addr % 4);
    if (sz == 2) return int'((addr % 4) / 2) * 2;
    return 0;
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] rdata, input logic [31:0] addr, input logic [2:0] mf);
    longint v;
    longint r;
    int sz;
    sz = load_size(mf);
    r  = longint'(rdata);
    v  = (r >> (8 * lane_off(sz, addr))) & ((longint'(1) << (8 * sz)) - 1);
    if ((mf == 3'd0 || mf == 3'd1) && v >= (longint'(1) << (8 * sz - 1)))
      v = v - (longint'(1) << (8 * sz));
    return v[31:0];
  endfunction

  function automatic logic [3:0] model_be(input logic [2:0] mf, input logic [31:0] addr);
    int sz;
    int be;
    sz = store_size(mf);
    be = ((1 << sz) - 1) << lane_off(sz, addr);
    return be[3:0];
  endfunction

  function automatic logic [31:0] model_wdata(input logic [2:0] mf, input logic [31:0] rt);
    logic [31:0] d;
    int sz;
    sz = store_size(mf);
    for (int i = 0; i < 4; i++) d[8*i +: 8] = rt[8*(i % sz) +: 8];
    return d;
  endfunction

  task automatic set_in(input logic rw, mr, m2r, mw, input logic [2:0] mf,
                        input logic [31:0] addr, rt, input logic [4:0] raddr);
    RegWriteIn = rw; MemReadIn = mr; MemtoRegIn = m2r; MemWriteIn = mw;
    MemfuncIn = mf; AddrIn = addr; RtDataIn = rt; RAddrIn = raddr;
  endtask

  task automatic do_op(input string tag, input vec_t v);
    logic is_mem;
    int   stall_cycles;
    is_mem = v.mr | v.mw;
    stall_cycles = 0;
    set_in(v.rw, v.mr, v.m2r, v.mw, v.mf, v.addr, v.rt, v.raddr);
    MemAck = 1'b0;
    #1;
    if (!is_mem) begin
      check({tag, " stall"}, 32'(Stall), 32'd0);
      tick();
      check({tag, " result"}, ResultOut, v.exp_res);
      check({tag, " regwrite"}, 32'(RegWriteOut), 32'(v.rw));
      check({tag, " raddr"}, 32'(RAddrOut), 32'(v.raddr));
      check({tag, " memtoreg"}, 32'(MemtoRegOut), 32'(v.m2r));
      return;
    end
    if (Stall) stall_cycles++;
    tick();
    check({tag, " req"}, 32'(MemReq), 32'd1);
    check({tag, " we"}, 32'(MemWe), 32'(v.mw));
    check({tag, " addr"}, MemAddr, v.addr & 32'hFFFF_FFFC);
    check({tag, " bubble"}, 32'(RegWriteOut), 32'd0);
    if (v.mw) begin
      check({tag, " be"}, 32'(MemBe), 32'(v.exp_be));
      check({tag, " wdata"}, MemWData, v.exp_wdata);
    end
    for (int i = 0; i < v.delay; i++) begin
      if (Stall) stall_cycles++;
      tick();
      check({tag, " req hold"}, 32'(MemReq), 32'd1);
      check({tag, " wait bubble"}, 32'(RegWriteOut), 32'd0);
    end
    MemAck = 1'b1;
    MemRData = v.rdata;
    #1;
    check({tag, " ack stall"}, 32'(Stall), 32'd0);
    check({tag, " stall cycles"}, 32'(stall_cycles), 32'(v.delay + 1));
    tick();
    MemAck = 1'b0;
    MemRData = $urandom;
    check({tag, " req drop"}, 32'(MemReq), 32'd0);
    check({tag, " result"}, ResultOut, v.exp_res);
    check({tag, " regwrite"}, 32'(RegWriteOut), 32'(v.rw));
    check({tag, " raddr"}, 32'(RAddrOut), 32'(v.raddr));
    check({tag, " memtoreg"}, 32'(MemtoRegOut), 32'(v.m2r));
  endtask

  initial begin
    vec_t v;
    logic [2:0] mf_pool [8];
    int sz;

    mf_pool = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3, 3'd6, 3'd7};
    //            rw  mr  m2r mw  mf    addr           rt             raddr  rdata          dly exp_res        be       wdata
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 32'h1234_5678, 32'h0,         5'd5,  32'h0,         0, 32'h1234_5678, 4'h0, 32'h0};
    tbl[1]  = '{1'b1, 1'b1, 1'b1, 1'b0, 3'd0, 32'h0000_0103, 32'h0,         5'd7,  32'h80FF_FF7F, 3, 32'hFFFF_FF80, 4'h0, 32'h0};
    tbl[2]  = '{1'b0, 1'b0, 1'b0, 1'b1, 3'd1, 32'h0000_0202, 32'hAAAA_BEEF, 5'd0,  32'h0,         1, 32'h0000_0202, 4'hC, 32'hBEEF_BEEF};
    tbl[3]  = '{1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 32'h0000_0301, 32'h1234_5678, 5'd0,  32'h0,         0, 32'h0000_0301, 4'h2, 32'h7878_7878};
    tbl[4]  = '{1'b1, 1'b1, 1'b1, 1'b0, 3'd5, 32'h0000_0002, 32'h0,         5'd9,  32'h8001_0000, 1, 32'h0000_8001, 4'h0, 32'h0};
    tbl[5]  = '{1'b1, 1'b1, 1'b1, 1'b0, 3'd1, 32'h0000_0006, 32'h0,         5'd10, 32'h8001_0000, 0, 32'hFFFF_8001, 4'h0, 32'h0};
    tbl[6]  = '{1'b1, 1'b1, 1'b1, 1'b0, 3'd2, 32'h0000_0010, 32'h0,         5'd11, 32'hDEAD_BEEF, 0, 32'hDEAD_BEEF, 4'h0, 32'h0};
    tbl[7]  = '{1'b1, 1'b1, 1'b0, 1'b0, 3'd4, 32'h0000_0001, 32'h0,         5'd12, 32'h0000_A500, 2, 32'h0000_00A5, 4'h0, 32'h0};
    tbl[8]  = '{1'b0, 1'b1, 1'b0, 1'b1, 3'd2, 32'h0000_0020, 32'h1122_3344, 5'd13, 32'hFFFF_FFFF, 0, 32'h0000_0020, 4'hF, 32'h1122_3344};
    tbl[9]  = '{1'b1, 1'b1, 1'b1, 1'b0, 3'd0, 32'h0000_0008, 32'h0,         5'd14, 32'h1234_567F, 0, 32'h0000_007F, 4'h0, 32'h0};
    tbl[10] = '{1'b1, 1'b1, 1'b1, 1'b0, 3'd3, 32'h0000_0014, 32'h0,         5'd15, 32'hCAFE_F00D, 1, 32'hCAFE_F00D, 4'h0, 32'h0};
    tbl[11] = '{1'b1, 1'b0, 1'b0, 1'b1, 3'd1, 32'h0000_0200, 32'h0000_BEEF, 5'd16, 32'h0,         0, 32'h0000_0200, 4'h3, 32'hBEEF_BEEF};
    tbl[12] = '{1'b0, 1'b0, 1'b1, 1'b0, 3'd2, 32'hFFFF_FFFF, 32'h0,         5'd31, 32'h0,         0, 32'hFFFF_FFFF, 4'h0, 32'h0};

    nReset = 1'b0;
    MemAck = 1'b0;
    MemRData = 32'h0;
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 32'h0, 32'h0, 5'd0);
    tick();
    tick();
    check("reset req", 32'(MemReq), 32'd0);
    check("reset stall", 32'(Stall), 32'd0);
    check("reset result", ResultOut, 32'd0);
    check("reset regwrite", 32'(RegWriteOut), 32'd0);
    check("reset be", 32'(MemBe), 32'd0);
    nReset = 1'b1;
    tick();

    for (int i = 0; i < 13; i++) do_op($sformatf("vec%0d", i), tbl[i]);

    // Reset while a request is outstanding, then a stray ack in IDLE.
    set_in(1'b1, 1'b1, 1'b1, 1'b0, 3'd2, 32'h0000_0040, 32'h0, 5'd3);
    #1;
    tick();
    check("rst busy req", 32'(MemReq), 32'd1);
    nReset = 1'b0;
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 32'h0, 32'h0, 5'd0);
    tick();
    check("rst busy req drop", 32'(MemReq), 32'd0);
    check("rst busy stall", 32'(Stall), 32'd0);
    check("rst busy addr", MemAddr, 32'd0);
    check("rst busy we", 32'(MemWe), 32'd0);
    check("rst busy wdata", MemWData, 32'd0);
    check("rst busy raddr", 32'(RAddrOut), 32'd0);
    nReset = 1'b1;
    MemAck = 1'b1;
    MemRData = 32'h5A5A_5A5A;
    set_in(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 32'h0000_0055, 32'h0, 5'd3);
    #1;
    check("stray ack stall", 32'(Stall), 32'd0);
    tick();
    MemAck = 1'b0;
    check("stray ack req", 32'(MemReq), 32'd0);
    check("stray ack result", ResultOut, 32'h0000_0055);

`ifdef MEM_ALIGN_CHECK_EN
    set_in(1'b1, 1'b1, 1'b1, 1'b0, 3'd2, 32'h0000_0101, 32'h0, 5'd4);
    #1;
    check("misalign stall", 32'(Stall), 32'd0);
    tick();
    check("misalign err", 32'(AddrErr), 32'd1);
    check("misalign req", 32'(MemReq), 32'd0);
    check("misalign regwrite", 32'(RegWriteOut), 32'd0);
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 32'h0, 32'h0, 5'd0);
    tick();
    check("misalign err pulse", 32'(AddrErr), 32'd0);
`endif

    for (int n = 0; n < 40; n++) begin
      int kind;
      kind      = int'($urandom_range(0, 2));
      v.mf      = mf_pool[$urandom_range(0, 7)];
      v.addr    = $urandom;
      v.rt      = $urandom;
      v.rdata   = $urandom;
      v.raddr   = 5'($urandom);
      v.rw      = 1'($urandom);
      v.m2r     = 1'($urandom);
      v.delay   = int'($urandom_range(0, 3));
      v.mr      = (kind == 1) ? 1'b1 : (kind == 2) ? 1'($urandom) : 1'b0;
      v.mw      = (kind == 2);
`ifdef MEM_ALIGN_CHECK_EN
      sz = v.mw ? store_size(v.mf) : load_size(v.mf);
      if (sz == 2) v.addr[0] = 1'b0;
      if (sz == 4) v.addr[1:0] = 2'b00;
`else
      sz = 0;
`endif
      v.exp_be    = model_be(v.mf, v.addr);
      v.exp_wdata = model_wdata(v.mf, v.rt);
      if (kind == 1)      v.exp_res = model_load(v.rdata, v.addr, v.mf);
      else                v.exp_res = v.addr;
      do_op($sformatf("rnd%0d", n), v);
    end

    set_in(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 32'h0, 32'h0, 5'd0);
    tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
